// File: rtl/dds_wg_pkg.sv
// Shared definitions for the UART command decoder: FSM state encoding,
// default command bytes, the write-ACK byte and a saturating increment helper.
package dds_wg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE,
    READ,
    TX_WAIT
  } state_t;

  localparam logic [7:0] DEF_CMD_WR = 8'h57;  // 'W'
  localparam logic [7:0] DEF_CMD_RD = 8'h52;  // 'R'
  localparam logic [7:0] ACK_BYTE   = 8'h06;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte gap counter: counts enabled cycles since the last clear and
// flags expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Holds at LAST rather than wrapping; the decoder leaves ADDR/DATA on expiry anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART byte-stream command decoder: "W addr data" writes, "R addr" reads and
// returns the register byte. Define UART_CMD_WR_ACK_EN to send an ACK after writes.
module uart_cmd_decoder
  import dds_wg_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  CMD_WR         = DEF_CMD_WR,
  parameter logic [7:0]  CMD_RD         = DEF_CMD_RD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic       rx_ready_o,
  output logic       tx_valid_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_ready_i,
  output logic       reg_wr_o,
  output logic       reg_rd_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_data_o,
  input  logic [7:0] reg_data_i,
  output logic [7:0] err_cnt_o
);

  state_t     r_state;
  state_t     w_state_next;
  logic       r_cmd_rd;
  logic [7:0] r_addr;
  logic [7:0] r_data;
  logic [7:0] r_tx_data;
  logic [7:0] r_err_cnt;

  logic       w_accept;
  logic       w_expire;
  logic       w_gap_clear;
  logic       w_gap_en;
  logic       w_err_inc;
  logic       w_is_cmd;

  assign w_accept    = rx_valid_i && rx_ready_o;
  assign w_is_cmd    = (rx_data_i == CMD_WR) || (rx_data_i == CMD_RD);
  assign w_gap_en    = (r_state == ADDR) || (r_state == DATA);
  assign w_gap_clear = w_accept || (r_state == IDLE);

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_gap_clear),
    .i_enable (w_gap_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // An accepted byte is checked before expiry so a late-but-in-time byte keeps the frame.
  always_comb begin
    w_state_next = r_state;
    w_err_inc    = 1'b0;
    rx_ready_o   = 1'b0;
    reg_wr_o     = 1'b0;
    reg_rd_o     = 1'b0;
    tx_valid_o   = 1'b0;
    case (r_state)
      IDLE: begin
        rx_ready_o = 1'b1;
        if (w_accept) begin
          if (w_is_cmd) begin
            w_state_next = ADDR;
          end else begin
            w_err_inc = 1'b1;
          end
        end
      end
      ADDR: begin
        rx_ready_o = 1'b1;
        if (w_accept) begin
          w_state_next = r_cmd_rd ? READ : DATA;
        end else if (w_expire) begin
          w_state_next = IDLE;
          w_err_inc    = 1'b1;
        end
      end
      DATA: begin
        rx_ready_o = 1'b1;
        if (w_accept) begin
          w_state_next = WRITE;
        end else if (w_expire) begin
          w_state_next = IDLE;
          w_err_inc    = 1'b1;
        end
      end
      WRITE: begin
        reg_wr_o = 1'b1;
`ifdef UART_CMD_WR_ACK_EN
        w_state_next = TX_WAIT;
`else
        w_state_next = IDLE;
`endif
      end
      READ: begin
        reg_rd_o     = 1'b1;
        w_state_next = TX_WAIT;
      end
      TX_WAIT: begin
        tx_valid_o = 1'b1;
        if (tx_ready_i) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_rd  <= 1'b0;
      r_addr    <= 8'h00;
      r_data    <= 8'h00;
      r_tx_data <= 8'h00;
      r_err_cnt <= 8'h00;
    end else begin
      if ((r_state == IDLE) && w_accept && w_is_cmd) begin
        r_cmd_rd <= (rx_data_i == CMD_RD);
      end
      if ((r_state == ADDR) && w_accept) begin
        r_addr <= rx_data_i;
      end
      if ((r_state == DATA) && w_accept) begin
        r_data <= rx_data_i;
      end
      if (r_state == READ) begin
        r_tx_data <= reg_data_i;
      end
`ifdef UART_CMD_WR_ACK_EN
      if (r_state == WRITE) begin
        r_tx_data <= ACK_BYTE;
      end
`endif
      if (w_err_inc) begin
        r_err_cnt <= sat_inc8(r_err_cnt);
      end
    end
  end

  assign reg_addr_o = r_addr;
  assign reg_data_o = r_data;
  assign tx_data_o  = r_tx_data;
  assign err_cnt_o  = r_err_cnt;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed-vector bench for uart_cmd_decoder with TIMEOUT_CYCLES=16; expects
// a write ACK byte only when UART_CMD_WR_ACK_EN is defined.
`timescale 1ns/1ps
module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid_i;
  logic [7:0] rx_data_i;
  logic       rx_ready_o;
  logic       tx_valid_o;
  logic [7:0] tx_data_o;
  logic       tx_ready_i;
  logic       reg_wr_o;
  logic       reg_rd_o;
  logic [7:0] reg_addr_o;
  logic [7:0] reg_data_o;
  logic [7:0] reg_data_i;
  logic [7:0] err_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_cmd_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid_i (rx_valid_i),
    .rx_data_i  (rx_data_i),
    .rx_ready_o (rx_ready_o),
    .tx_valid_o (tx_valid_o),
    .tx_data_o  (tx_data_o),
    .tx_ready_i (tx_ready_i),
    .reg_wr_o   (reg_wr_o),
    .reg_rd_o   (reg_rd_o),
    .reg_addr_o (reg_addr_o),
    .reg_data_o (reg_data_o),
    .reg_data_i (reg_data_i),
    .err_cnt_o  (err_cnt_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    step();
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
  endtask

  // Called one cycle into WRITE; leaves the decoder back in IDLE.
  task automatic finish_write(input string tag);
    step();
    check_val({tag, "_wr_one_cycle"}, {31'd0, reg_wr_o}, 32'd0);
`ifdef UART_CMD_WR_ACK_EN
    check_val({tag, "_ack_valid"}, {31'd0, tx_valid_o}, 32'd1);
    check_val({tag, "_ack_data"}, {24'd0, tx_data_o}, 32'h06);
    tx_ready_i = 1'b1;
    step();
    tx_ready_i = 1'b0;
    check_val({tag, "_ack_done"}, {31'd0, tx_valid_o}, 32'd0);
`else
    check_val({tag, "_no_ack"}, {31'd0, tx_valid_o}, 32'd0);
`endif
    check_val({tag, "_idle_ready"}, {31'd0, rx_ready_o}, 32'd1);
  endtask

  // Strobes and tx_valid must be mutually exclusive at all times.
  always @(negedge clk) begin
    if (!rst) begin
      check_val("exclusive", {30'd0, 2'(reg_wr_o + reg_rd_o + tx_valid_o) > 2'd1}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic wr_seen;
    logic hold_bad;
    rst = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i = 8'h00;
    tx_ready_i = 1'b0;
    reg_data_i = 8'h00;
    #2;
    check_val("rst_rx_ready", {31'd0, rx_ready_o}, 32'd1);
    check_val("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
    check_val("rst_err_cnt", {24'd0, err_cnt_o}, 32'd0);
    check_val("rst_addr", {24'd0, reg_addr_o}, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Write frame
    send_byte(8'h57);
    send_byte(8'h01);
    send_byte(8'h34);
    check_val("wr_strobe", {31'd0, reg_wr_o}, 32'd1);
    check_val("wr_addr", {24'd0, reg_addr_o}, 32'h01);
    check_val("wr_data", {24'd0, reg_data_o}, 32'h34);
    check_val("wr_no_rd", {31'd0, reg_rd_o}, 32'd0);
    finish_write("wr");
    $display("txn write addr=01 data=34");

    // Read frame with backpressure on TX
    reg_data_i = 8'hA5;
    send_byte(8'h52);
    send_byte(8'h02);
    check_val("rd_strobe", {31'd0, reg_rd_o}, 32'd1);
    check_val("rd_addr", {24'd0, reg_addr_o}, 32'h02);
    check_val("rd_no_tx_yet", {31'd0, tx_valid_o}, 32'd0);
    step();
    reg_data_i = 8'h5A;
    check_val("rd_strobe_once", {31'd0, reg_rd_o}, 32'd0);
    check_val("rd_tx_valid", {31'd0, tx_valid_o}, 32'd1);
    check_val("rd_tx_data", {24'd0, tx_data_o}, 32'hA5);
    hold_bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tx_data_o !== 8'hA5 || rx_ready_o !== 1'b0 || tx_valid_o !== 1'b1) hold_bad = 1'b1;
    end
    check_val("rd_hold_50", {31'd0, hold_bad}, 32'd0);
    tx_ready_i = 1'b1;
    step();
    tx_ready_i = 1'b0;
    check_val("rd_tx_done", {31'd0, tx_valid_o}, 32'd0);
    check_val("rd_back_idle", {31'd0, rx_ready_o}, 32'd1);
    $display("txn read addr=02 data=A5");

    // Unknown command byte
    send_byte(8'h33);
    check_val("bad_err1", {24'd0, err_cnt_o}, 32'd1);
    check_val("bad_no_wr", {31'd0, reg_wr_o}, 32'd0);
    check_val("bad_ready", {31'd0, rx_ready_o}, 32'd1);
    $display("txn bad byte 33");

    // Timeout in DATA: 15 idle cycles keep the frame, the 16th aborts it
    send_byte(8'h57);
    send_byte(8'h01);
    wr_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      wr_seen |= reg_wr_o;
    end
    check_val("to_not_yet", {24'd0, err_cnt_o}, 32'd1);
    step();
    wr_seen |= reg_wr_o;
    check_val("to_err2", {24'd0, err_cnt_o}, 32'd2);
    step();
    wr_seen |= reg_wr_o;
    check_val("to_no_wr", {31'd0, wr_seen}, 32'd0);
    $display("txn data timeout");

    // Byte in the expiry cycle wins
    send_byte(8'h57);
    send_byte(8'h01);
    for (int i = 0; i < 15; i++) step();
    send_byte(8'h34);
    check_val("late_wr", {31'd0, reg_wr_o}, 32'd1);
    check_val("late_data", {24'd0, reg_data_o}, 32'h34);
    check_val("late_err", {24'd0, err_cnt_o}, 32'd2);
    finish_write("late");
    $display("txn byte at expiry");

    // Timeout in ADDR
    send_byte(8'h52);
    for (int i = 0; i < 15; i++) step();
    check_val("to_addr_wait", {24'd0, err_cnt_o}, 32'd2);
    step();
    check_val("to_addr_err3", {24'd0, err_cnt_o}, 32'd3);
    $display("txn addr timeout");

    // Reset mid-TX_WAIT
    reg_data_i = 8'hC3;
    send_byte(8'h52);
    send_byte(8'h03);
    step();
    check_val("rst_tx_pre", {31'd0, tx_valid_o}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("rst_tx_drop", {31'd0, tx_valid_o}, 32'd0);
    check_val("rst_tx_ready", {31'd0, rx_ready_o}, 32'd1);
    check_val("rst_tx_err", {24'd0, err_cnt_o}, 32'd0);
    check_val("rst_tx_data", {24'd0, tx_data_o}, 32'd0);
    step();
    rst = 1'b0;
    step();
    $display("txn reset during tx_wait");

    // Saturation
    for (int i = 0; i < 300; i++) begin
      send_byte(8'h00);
      if (i == 253) check_val("sat_fe", {24'd0, err_cnt_o}, 32'hFE);
      if (i == 254) check_val("sat_ff", {24'd0, err_cnt_o}, 32'hFF);
    end
    check_val("sat_hold", {24'd0, err_cnt_o}, 32'hFF);
    $display("txn 300 bad bytes");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
